// File: rtl/demux_scan_ctrl.sv
// Serializes 8-bit frames onto a 1-to-8 demux: each unmasked channel i gets a
// guard phase (S=i, D=0) and a dwell phase (S=i, D=bit i); a one-cycle DONE ends the frame.
module demux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int GUARD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_mask,
  input  logic       abort,
  output logic [2:0] S,
  output logic       D,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, GAP, DRIVE, DONE} state_t;

  localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);
  localparam logic [1:0] GUARD_M1 = (GUARD > 0) ? 2'(GUARD - 1) : 2'd0;

  state_t     state, state_n;
  logic [2:0] ch, ch_n;
  logic [1:0] gcnt, gcnt_n;
  logic [3:0] dcnt, dcnt_n;
  logic [7:0] data_q, mask_q, data_n, mask_n;
  logic [2:0] s_n;
  logic       d_n, busy_n, done_n, rdy_n;
  logic       accept, start;
  logic [2:0] start_ch;
  logic [3:0] first_ch, next_ch;

  // Returns {found, index} of the lowest unmasked channel at or above 'from'.
  function automatic logic [3:0] find_unmasked(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i >= int'(from) && !mask[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign accept   = in_valid && in_ready;
  assign first_ch = find_unmasked(in_mask, 4'd0);
  assign next_ch  = find_unmasked(mask_q, {1'b0, ch} + 4'd1);

  always_comb begin
    state_n  = state;
    ch_n     = ch;
    gcnt_n   = gcnt;
    dcnt_n   = dcnt;
    data_n   = data_q;
    mask_n   = mask_q;
    s_n      = S;
    d_n      = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    rdy_n    = 1'b1;
    start    = 1'b0;
    start_ch = ch;
    if (accept) begin
      // Accept takes priority over abort: in_ready=1 means the frame is committed.
      data_n = in_data;
      mask_n = in_mask;
      if (first_ch[3]) begin
        start    = 1'b1;
        start_ch = first_ch[2:0];
      end else begin
        state_n = DONE;
        done_n  = 1'b1;
      end
    end else begin
      case (state)
        GAP: begin
          if (abort) begin
            state_n = IDLE;
          end else if (gcnt == 2'd0) begin
            state_n = DRIVE;
            dcnt_n  = DWELL_M1;
            d_n     = data_q[ch];
            busy_n  = 1'b1;
            rdy_n   = 1'b0;
          end else begin
            gcnt_n = gcnt - 2'd1;
            busy_n = 1'b1;
            rdy_n  = 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state_n = IDLE;
          end else if (dcnt == 4'd0) begin
            if (next_ch[3]) begin
              start    = 1'b1;
              start_ch = next_ch[2:0];
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            dcnt_n = dcnt - 4'd1;
            d_n    = data_q[ch];
            busy_n = 1'b1;
            rdy_n  = 1'b0;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    // S moves at the start of each channel's guard (or dwell when there is no guard).
    if (start) begin
      ch_n   = start_ch;
      s_n    = start_ch;
      busy_n = 1'b1;
      rdy_n  = 1'b0;
      if (GUARD > 0) begin
        state_n = GAP;
        gcnt_n  = GUARD_M1;
      end else begin
        state_n = DRIVE;
        dcnt_n  = DWELL_M1;
        d_n     = data_n[start_ch];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= 3'd0;
      gcnt       <= 2'd0;
      dcnt       <= 4'd0;
      S          <= 3'd0;
      D          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_n;
      ch         <= ch_n;
      gcnt       <= gcnt_n;
      dcnt       <= dcnt_n;
      S          <= s_n;
      D          <= d_n;
      busy       <= busy_n;
      frame_done <= done_n;
      in_ready   <= rdy_n;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_n;
    mask_q <= mask_n;
  end

endmodule
